// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one host mem port between NUM_REQ requesters.
// Define MEM_ARB_TIMEOUT_EN to add the sticky write-beat watchdog (timeout_err).
module mem_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 32,
  parameter int MEM_DATA_BITS = 64,
  parameter int TIMEOUT       = 1024
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0]                 req_opcode,
  input  logic [NUM_REQ*MEM_LEN_BITS-1:0]    req_len,
  input  logic [NUM_REQ*MEM_ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]                 wr_valid,
  output logic [NUM_REQ-1:0]                 wr_ready,
  input  logic [NUM_REQ*MEM_DATA_BITS-1:0]   wr_bits,
  output logic [NUM_REQ-1:0]                 rd_valid,
  output logic [MEM_DATA_BITS-1:0]           rd_bits,
  input  logic [NUM_REQ-1:0]                 rd_ready,
  output logic                               mem_req_valid,
  output logic                               mem_req_opcode,
  output logic [MEM_LEN_BITS-1:0]            mem_req_len,
  output logic [MEM_ADDR_BITS-1:0]           mem_req_addr,
  output logic                               mem_wr_valid,
  output logic [MEM_DATA_BITS-1:0]           mem_wr_bits,
  input  logic                               mem_rd_valid,
  input  logic [MEM_DATA_BITS-1:0]           mem_rd_bits,
  output logic                               mem_rd_ready,
  output logic                               timeout_err
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, READ, WRITE} state_e;

  state_e                   state_q;
  logic [IW-1:0]            rr_q, rr_d, gnt_q, pick;
  logic                     op_q;
  logic [MEM_LEN_BITS-1:0]  len_q, cnt_q;
  logic [MEM_ADDR_BITS-1:0] addr_q;
  logic                     any_req, beat, abort;
  int                       idx;

  // Scan downward so the last hit is the first requester at or above rr_q (with wrap).
  always_comb begin
    pick = rr_q;
    idx  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) pick = IW'(idx);
    end
  end

  assign any_req = |req_valid;
  assign rr_d    = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
  assign beat    = ((state_q == READ) && mem_rd_valid && rd_ready[gnt_q]) ||
                   ((state_q == WRITE) && wr_valid[gnt_q]);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic          timeout_err_q;

  assign abort       = (state_q == WRITE) && !wr_valid[gnt_q] && (tmo_q == TW'(TIMEOUT - 1));
  assign timeout_err = timeout_err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q != WRITE || wr_valid[gnt_q] || abort) tmo_q <= '0;
      else                                              tmo_q <= tmo_q + 1'b1;
      if (abort) timeout_err_q <= 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT != 0);
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      op_q    <= 1'b0;
      len_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          gnt_q   <= pick;
          op_q    <= req_opcode[pick];
          len_q   <= req_len[int'(pick)*MEM_LEN_BITS +: MEM_LEN_BITS];
          addr_q  <= req_addr[int'(pick)*MEM_ADDR_BITS +: MEM_ADDR_BITS];
          state_q <= ISSUE;
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= op_q ? WRITE : READ;
        end
        READ, WRITE: begin
          if (abort || (beat && cnt_q == len_q)) begin
            state_q <= IDLE;
            rr_q    <= rr_d;
          end else if (beat) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // req_ready is combinational, so it is gated by reset_n to stay low during reset.
  always_comb begin
    req_ready = '0;
    if (reset_n && state_q == IDLE && any_req) req_ready[pick] = 1'b1;
    rd_valid = '0;
    if (state_q == READ) rd_valid[gnt_q] = mem_rd_valid;
    wr_ready = '0;
    if (state_q == WRITE) wr_ready[gnt_q] = 1'b1;
  end

  assign rd_bits        = (state_q == READ)  ? mem_rd_bits : '0;
  assign mem_rd_ready   = (state_q == READ)  && rd_ready[gnt_q];
  assign mem_wr_valid   = (state_q == WRITE) && wr_valid[gnt_q];
  assign mem_wr_bits    = (state_q == WRITE) ? wr_bits[int'(gnt_q)*MEM_DATA_BITS +: MEM_DATA_BITS] : '0;
  assign mem_req_valid  = (state_q == ISSUE);
  assign mem_req_opcode = (state_q == ISSUE) && op_q;
  assign mem_req_len    = (state_q == ISSUE) ? len_q  : '0;
  assign mem_req_addr   = (state_q == ISSUE) ? addr_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic checked against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int N = 2, LB = 8, AB = 32, DB = 64, TMO = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0]    req_valid, req_ready, req_opcode, wr_valid, wr_ready, rd_valid, rd_ready;
  logic [N*LB-1:0] req_len;
  logic [N*AB-1:0] req_addr;
  logic [N*DB-1:0] wr_bits;
  logic [DB-1:0]   rd_bits, mem_wr_bits, mem_rd_bits;
  logic [LB-1:0]   mem_req_len;
  logic [AB-1:0]   mem_req_addr;
  logic mem_req_valid, mem_req_opcode, mem_wr_valid, mem_rd_valid, mem_rd_ready, timeout_err;

  mem_arbiter #(.NUM_REQ(N), .MEM_LEN_BITS(LB), .MEM_ADDR_BITS(AB),
                .MEM_DATA_BITS(DB), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_len(req_len), .req_addr(req_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_bits(wr_bits),
    .rd_valid(rd_valid), .rd_bits(rd_bits), .rd_ready(rd_ready),
    .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode),
    .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr),
    .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
    .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits), .mem_rd_ready(mem_rd_ready),
    .timeout_err(timeout_err));

  always #5 clock = ~clock;

  // requester-side stimulus state
  logic [N-1:0]  pend, keep_mask, clr_mask;
  logic [N-1:0]  op_r;
  logic [LB-1:0] len_r [N];
  logic [AB-1:0] addr_r [N];
  int wr_pct, rd_pct, rdy_pct;

  always_comb begin
    req_valid = pend;
    req_len   = '0;
    req_addr  = '0;
    for (int i = 0; i < N; i++) begin
      req_opcode[i]          = op_r[i];
      req_len[i*LB +: LB]    = len_r[i];
      req_addr[i*AB +: AB]   = addr_r[i];
    end
  end

  // transaction-level reference model
  int rr, cur_g, left, stall, exp_err, obs_rd, obs_wr;
  logic issue, cur_op;
  logic [LB-1:0] cur_len;
  logic [AB-1:0] cur_addr;
  int gq[$];
  int tests, fails;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick();
    for (int k = 0; k < N; k++) if (pend[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic op, input int len, input logic [AB-1:0] addr);
    op_r[i]   = op;
    len_r[i]  = LB'(len);
    addr_r[i] = addr;
    pend[i]   = 1'b1;
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) begin
      wr_valid[i]          = ($urandom_range(0, 99) < wr_pct);
      rd_ready[i]          = ($urandom_range(0, 99) < rdy_pct);
      wr_bits[i*DB +: DB]  = {$urandom, $urandom};
    end
    mem_rd_valid = ($urandom_range(0, 99) < rd_pct);
    mem_rd_bits  = {$urandom, $urandom};
  endtask

  task automatic finish_txn();
    rr    = (cur_g + 1) % N;
    cur_g = -1;
  endtask

  // One clock: check mid-cycle against the model, then retire accepted requests after the edge.
  task automatic step();
    int g;
    logic [N-1:0] exp_v;
    @(negedge clock); #1;
    obs_rd += $countones(rd_valid & rd_ready);
    obs_wr += $countones(wr_ready & wr_valid);
    check_val("timeout_err", timeout_err, exp_err);
    if (issue) begin
      check_val("mem_req_valid", mem_req_valid, 1);
      check_val("mem_req_opcode", mem_req_opcode, cur_op);
      check_val("mem_req_len", mem_req_len, cur_len);
      check_val("mem_req_addr", mem_req_addr, cur_addr);
      check_val("req_ready_busy", req_ready, 0);
      issue = 1'b0;
      left  = int'(cur_len) + 1;
      stall = 0;
    end else begin
      check_val("mem_req_idle", mem_req_valid, 0);
      if (cur_g < 0) begin
        exp_v = '0;
        if (pend != '0) begin
          g        = rr_pick();
          exp_v[g] = 1'b1;
          cur_g    = g;
          cur_op   = op_r[g];
          cur_len  = len_r[g];
          cur_addr = addr_r[g];
          issue    = 1'b1;
          gq.push_back(g);
          if (!keep_mask[g]) clr_mask[g] = 1'b1;
        end
        check_val("req_ready", req_ready, exp_v);
      end else if (!cur_op) begin
        exp_v = '0;
        exp_v[cur_g] = mem_rd_valid;
        check_val("rd_valid", rd_valid, exp_v);
        check_val("rd_bits", rd_bits, mem_rd_bits);
        check_val("mem_rd_ready", mem_rd_ready, rd_ready[cur_g]);
        check_val("req_ready_busy", req_ready, 0);
        if (mem_rd_valid && rd_ready[cur_g]) begin
          left--;
          if (left == 0) finish_txn();
        end
      end else begin
        exp_v = '0;
        exp_v[cur_g] = 1'b1;
        check_val("wr_ready", wr_ready, exp_v);
        check_val("mem_wr_valid", mem_wr_valid, wr_valid[cur_g]);
        if (wr_valid[cur_g]) check_val("mem_wr_bits", mem_wr_bits, wr_bits[cur_g*DB +: DB]);
        check_val("req_ready_busy", req_ready, 0);
        if (wr_valid[cur_g]) begin
          stall = 0;
          left--;
          if (left == 0) finish_txn();
        end else begin
          stall++;
`ifdef MEM_ARB_TIMEOUT_EN
          if (stall == TMO) begin
            exp_err = 1;
            finish_txn();
          end
`endif
        end
      end
    end
    @(posedge clock); #1;
    pend     = pend & ~clr_mask;
    clr_mask = '0;
  endtask

  task automatic run_until_idle(input int max);
    int n;
    logic busy_now;
    n = 0;
    while ((cur_g >= 0 || issue || pend != '0) && n < max) begin
      drive_data();
      step();
      n++;
    end
    busy_now = (cur_g >= 0) || issue || (pend != '0);
    check_val("drain_bound", busy_now, 0);
  endtask

  initial begin
    int o;
    tests = 0; fails = 0;
    rr = 0; cur_g = -1; left = 0; stall = 0; exp_err = 0; obs_rd = 0; obs_wr = 0;
    issue = 1'b0; cur_op = 1'b0; cur_len = '0; cur_addr = '0;
    pend = '0; keep_mask = '0; clr_mask = '0; op_r = '0;
    for (int i = 0; i < N; i++) begin len_r[i] = '0; addr_r[i] = '0; end
    wr_pct = 100; rd_pct = 100; rdy_pct = 100;
    drive_data();

    // reset: even with requests pending, every output stays low
    set_req(0, 1'b0, 1, 32'h10);
    set_req(1, 1'b1, 1, 32'h20);
    #3;
    check_val("rst_req_ready", req_ready, 0);
    check_val("rst_mem_req_valid", mem_req_valid, 0);
    check_val("rst_wr_ready", wr_ready, 0);
    check_val("rst_timeout_err", timeout_err, 0);
    pend = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // simultaneous writes len=1: 0 then 1, two beats each
    gq.delete(); o = obs_wr;
    set_req(0, 1'b1, 1, 32'hA000);
    set_req(1, 1'b1, 1, 32'hB000);
    run_until_idle(40);
    check_val("sim_grants", gq.size(), 2);
    check_val("sim_first", gq[0], 0);
    check_val("sim_second", gq[1], 1);
    check_val("sim_wr_beats", obs_wr - o, 4);

    // both requesting continuously: grants alternate
    gq.delete();
    keep_mask = '1;
    set_req(0, 1'b0, 1, 32'hC000);
    set_req(1, 1'b1, 2, 32'hD000);
    for (int n = 0; n < 200 && gq.size() < 4; n++) begin drive_data(); step(); end
    keep_mask = '0;
    run_until_idle(60);
    check_val("alt_count", (gq.size() >= 4), 1);
    for (int k = 0; k < 4 && k < gq.size(); k++) check_val("alt_order", gq[k], k % 2);

    // single read, len=3, read data every cycle
    o = obs_rd;
    set_req(0, 1'b0, 3, 32'h1000);
    run_until_idle(20);
    check_val("rd4_beats", obs_rd - o, 4);

    // read len=0 with rd_ready held low for 5 cycles
    o = obs_rd; rdy_pct = 0;
    set_req(1, 1'b0, 0, 32'h2000);
    repeat (7) begin drive_data(); step(); end
    check_val("rd_hold_beats", obs_rd - o, 0);
    rdy_pct = 100;
    run_until_idle(10);
    check_val("rd_len0_beats", obs_rd - o, 1);

    // maximum length write: 256 beats
    o = obs_wr;
    set_req(1, 1'b1, 255, 32'h3000);
    run_until_idle(300);
    check_val("wr256_beats", obs_wr - o, 256);

    // reset during beat 2 of a len=7 write
    set_req(0, 1'b1, 7, 32'h4000);
    repeat (4) begin drive_data(); step(); end
    drive_data();
    set_req(0, 1'b0, 1, 32'h5000);
    set_req(1, 1'b0, 1, 32'h6000);
    #2 reset_n = 1'b0;
    #1;
    check_val("arst_wr_ready", wr_ready, 0);
    check_val("arst_mem_wr_valid", mem_wr_valid, 0);
    check_val("arst_mem_wr_bits", mem_wr_bits, 0);
    check_val("arst_req_ready", req_ready, 0);
    check_val("arst_rd_valid", rd_valid, 0);
    check_val("arst_mem_req_valid", mem_req_valid, 0);
    cur_g = -1; issue = 1'b0; rr = 0; exp_err = 0; clr_mask = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    gq.delete();
    run_until_idle(20);
    check_val("arst_first_grant", gq[0], 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // write with no data: watchdog aborts after TMO stalled cycles
    wr_pct = 0;
    set_req(0, 1'b1, 3, 32'h7000);
    run_until_idle(TMO + 10);
    check_val("tmo_flag", timeout_err, 1);
    wr_pct = 100; gq.delete(); o = obs_rd;
    set_req(1, 1'b0, 1, 32'h8000);
    run_until_idle(20);
    check_val("tmo_next_grant", gq[0], 1);
    check_val("tmo_next_beats", obs_rd - o, 2);
`endif

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      if (n % 200 == 0) begin
        wr_pct  = $urandom_range(40, 100);
        rd_pct  = $urandom_range(40, 100);
        rdy_pct = $urandom_range(40, 100);
      end
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 99) < 25)
          set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom);
      drive_data();
      step();
    end
    wr_pct = 100; rd_pct = 100; rdy_pct = 100;
    run_until_idle(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation exceeded time bound");
    $fatal(1);
  end

endmodule
